// File: rtl/top_sdiv_9s_2ns_9_seq_1.sv
// Sequential signed-by-unsigned restoring divider with a start/done handshake.
// It takes one quotient bit per enabled cycle. Quotient and remainder follow C truncation semantics.
module top_sdiv_9s_2ns_9_seq_1 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 2,
    parameter int dout_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   remd
);

    localparam int W  = din0_WIDTH;
    localparam int PW = din1_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(din0_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_neg;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_q;
    logic [din1_WIDTH-1:0] r_b;
    logic [PW-1:0]         r_p;
    logic                  r_done;
    logic [dout_WIDTH-1:0] r_dout;
    logic [PW-1:0]         r_remd;

    logic [PW:0]           w_t;
    logic [PW:0]           w_b;
    logic                  w_ge;
    logic [PW-1:0]         w_p_next;
    logic [W-1:0]          w_mag;

    // One restoring step: the guard bit in w_t keeps the compare exact before the result is narrowed back into p.
    always_comb begin
        w_t      = {r_p, r_a[W-1]};
        w_b      = (PW + 1)'(r_b);
        w_ge     = (w_t >= w_b);
        w_mag    = din0[W-1] ? (W'(0) - din0) : din0;
        w_p_next = w_t[PW-1:0];
        if (w_ge) begin
            w_p_next = w_t[PW-1:0] - w_b[PW-1:0];
        end else begin
            w_p_next = w_t[PW-1:0];
        end
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_FIX;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; ce=0 freezes the sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_a    <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_done <= 1'b0;
            r_dout <= '0;
            r_remd <= '0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_neg <= din0[W-1];
                        r_a   <= w_mag;
                        r_b   <= din1;
                        r_p   <= '0;
                        r_q   <= '0;
                        r_cnt <= CNT_INIT;
                    end
                end
                S_CALC: begin
                    r_a   <= {r_a[W-2:0], 1'b0};
                    r_q   <= {r_q[W-2:0], w_ge};
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - CNT_LAST;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    // A zero divisor leaves garbage in p; the result is forced instead.
                    if (r_b == '0) begin
                        r_dout <= '1;
                        r_remd <= '0;
                    end else begin
                        r_dout <= r_neg ? dout_WIDTH'(W'(0) - r_q) : dout_WIDTH'(r_q);
                        r_remd <= r_neg ? (PW'(0) - r_p) : r_p;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign dout = r_dout;
    assign remd = r_remd;

endmodule

// File: tb/tb_top_sdiv_9s_2ns_9_seq_1.sv
// Directed bench for top_sdiv_9s_2ns_9_seq_1. Every expected quotient, remainder and latency is written out by hand.
module tb_top_sdiv_9s_2ns_9_seq_1;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       start;
    logic [8:0] din0;
    logic [1:0] din1;
    logic       done;
    logic [8:0] dout;
    logic [2:0] remd;

    int n_checks;
    int n_fail;

    top_sdiv_9s_2ns_9_seq_1 #(
        .ID(1), .din0_WIDTH(9), .din1_WIDTH(2), .dout_WIDTH(9)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .done(done), .dout(dout), .remd(remd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one division. A busy start is pulsed mid-CALC. An optional 4-cycle ce stall starts after stall_at cycles.
    task automatic run_op(input string tag, input logic [8:0] a, input logic [1:0] b,
                          input int stall_at, input logic [8:0] exp_q,
                          input logic [2:0] exp_r, input int exp_lat);
        int n;
        logic got;
        start = 1'b1; din0 = a; din1 = b;
        tick();
        start = 1'b0; din0 = ~a; din1 = ~b;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            if (n == stall_at) ce = 1'b0;
            if (n == stall_at + 4) ce = 1'b1;
            if (n == 4) begin
                start = 1'b1; din0 = 9'h055; din1 = 2'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (done) got = 1'b1;
        end
        ce = 1'b1; start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_dout"}, 32'(dout), 32'(exp_q));
        chk({tag, "_remd"}, 32'(remd), 32'(exp_r));
        tick();
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int dcount;
        logic got;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = 9'd0; din1 = 2'd0;
        tick(); tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_remd", 32'(remd), 32'd0);
        reset = 1'b0;
        tick();

        run_op("pos_100_3",  9'd100, 2'd3, -10, 9'd33,  3'd1,   10);
        run_op("neg_100_3",  9'h19C, 2'd3, -10, 9'h1DF, 3'b111, 10);
        run_op("neg_256_1",  9'h100, 2'd1, -10, 9'h100, 3'd0,   10);
        run_op("div0_7",     9'd7,   2'd0, -10, 9'h1FF, 3'd0,   10);
        run_op("pos_5_3",    9'd5,   2'd3, -10, 9'd1,   3'd2,   10);
        run_op("neg_5_3",    9'h1FB, 2'd3, -10, 9'h1FF, 3'b110, 10);
        run_op("neg_7_2",    9'h1F9, 2'd2, -10, 9'h1FD, 3'b111, 10);
        run_op("stall_100_3", 9'd100, 2'd3, 3,  9'd33,  3'd1,   14);

        // Back-to-back: start stays high through CALC and the done cycle of 255/3.
        start = 1'b1; din0 = 9'd255; din1 = 2'd3;
        tick();
        din0 = 9'd100; din1 = 2'd3;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            tick(); n++;
            if (done) got = 1'b1;
        end
        chk("b2b_first_latency", 32'(n), 32'd10);
        chk("b2b_first_dout", 32'(dout), 32'd85);
        chk("b2b_first_remd", 32'(remd), 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_done_fall", 32'(done), 32'd0);
        n = 1; got = 1'b0;
        while (n < 40 && !got) begin
            tick(); n++;
            if (done) got = 1'b1;
        end
        chk("b2b_second_latency", 32'(n), 32'd11);
        chk("b2b_second_dout", 32'(dout), 32'd33);
        chk("b2b_second_remd", 32'(remd), 32'd1);

        // done and the results hold while ce is low.
        ce = 1'b0;
        tick();
        chk("ce_hold_done", 32'(done), 32'd1);
        chk("ce_hold_dout", 32'(dout), 32'd33);
        ce = 1'b1;
        tick();
        chk("ce_release_done", 32'(done), 32'd0);
        chk("ce_release_dout", 32'(dout), 32'd33);

        // Reset in the middle of an operation.
        start = 1'b1; din0 = 9'd255; din1 = 2'd1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_remd", 32'(remd), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        run_op("post_rst_100_3", 9'd100, 2'd3, -10, 9'd33, 3'd1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
